clb_cfg_chain: RTL and testbench



---
 rtl/clb_cfg_pkg.sv | 19 +
 rtl/clb_cfg_segment.sv | 30 +++
 rtl/clb_cfg_chain.sv | 98 +++++++++
 tb/tb_clb_cfg_chain.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/clb_cfg_pkg.sv
// Shared types and sizing helpers for the CLB configuration chain.
package clb_cfg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_FULL  = 2'd2
   } cfg_state_e;

   // Each segment is its data bits plus one even-parity bit.
   function automatic int chain_len(input int num_subtiles, input int cfg_bits);
      return num_subtiles * (cfg_bits + 1);
   endfunction

   function automatic int seg_offset(input int seg, input int cfg_bits);
      return seg * (cfg_bits + 1);
   endfunction

endpackage

// File: rtl/clb_cfg_segment.sv
// One subtile's slice of the configuration shift chain, with its even-parity check.
module clb_cfg_segment #(
   parameter int CFG_BITS = 64
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              en_i,
   input  logic              din_i,
   output logic [CFG_BITS:0] bits_o,
   output logic              par_ok_o
);

   logic [CFG_BITS:0] sr_q;
   logic [CFG_BITS:0] sr_d;

   always_comb sr_d = {sr_q[CFG_BITS-1:0], din_i};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sr_q <= '0;
      end else if (en_i) begin
         sr_q <= sr_d;
      end
   end

   assign bits_o   = sr_q;
   // Data plus parity bit must hold an even number of ones.
   assign par_ok_o = ~^sr_q;

endmodule

// File: rtl/clb_cfg_chain.sv
// Configuration chain: serial shift-in, pass-through tail, and a parity-checked
// double-buffered commit into the fabric configuration register.
module clb_cfg_chain
   import clb_cfg_pkg::*;
#(
   parameter int NUM_SUBTILES = 1,
   parameter int CFG_BITS     = 64
) (
   input  logic                             prog_clk,
   input  logic                             prog_reset,
   input  logic                             ccff_head,
   input  logic                             ccff_en,
   input  logic                             ccff_commit,
   output logic                             ccff_tail,
   output logic [NUM_SUBTILES*CFG_BITS-1:0] cfg_out,
   output logic                             cfg_valid,
   output logic                             cfg_busy,
   output logic                             cfg_err,
   output cfg_state_e                       dbg_state_o,
   output logic [$clog2(chain_len(NUM_SUBTILES, CFG_BITS)+1)-1:0] dbg_cnt_o
);

   localparam int CHAIN_LEN = chain_len(NUM_SUBTILES, CFG_BITS);
   localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CHAIN_LEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

   logic [CHAIN_LEN-1:0]             sr_w;
   logic [NUM_SUBTILES-1:0]          par_ok_w;
   logic [NUM_SUBTILES*CFG_BITS-1:0] cfg_d;

   cfg_state_e                       state_q;
   logic [CNT_W-1:0]                 cnt_q;
   logic                             tail_q;
   logic [NUM_SUBTILES*CFG_BITS-1:0] cfg_q;
   logic                             valid_q;
   logic                             err_q;

   // Segment k starts at bit seg_offset(k); its input is the previous segment's parity bit.
   for (genvar k = 0; k < NUM_SUBTILES; k++) begin : g_seg
      localparam int OFS = seg_offset(k, CFG_BITS);
      logic din_w;
      if (k == 0) begin : g_head
         assign din_w = ccff_head;
      end else begin : g_link
         assign din_w = sr_w[OFS-1];
      end
      clb_cfg_segment #(.CFG_BITS(CFG_BITS)) u_seg (
         .clk_i    (prog_clk),
         .rst_i    (prog_reset),
         .en_i     (ccff_en),
         .din_i    (din_w),
         .bits_o   (sr_w[OFS +: CFG_BITS+1]),
         .par_ok_o (par_ok_w[k])
      );
      assign cfg_d[k*CFG_BITS +: CFG_BITS] = sr_w[OFS +: CFG_BITS];
   end

   always_ff @(posedge prog_clk) begin
      if (prog_reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         tail_q  <= 1'b0;
         cfg_q   <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else if (ccff_en) begin
         // A commit coinciding with a shift is rejected; the shift still happens.
         tail_q  <= sr_w[CHAIN_LEN-1];
         state_q <= (cnt_q >= CNT_LAST) ? ST_FULL : ST_SHIFT;
         if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
         end
         if (ccff_commit) begin
            err_q <= 1'b1;
         end
      end else if (ccff_commit) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         if ((cnt_q == CNT_MAX) && (&par_ok_w)) begin
            cfg_q   <= cfg_d;
            valid_q <= 1'b1;
            err_q   <= 1'b0;
         end else begin
            err_q <= 1'b1;
         end
      end
   end

   assign ccff_tail   = tail_q;
   assign cfg_out     = cfg_q;
   assign cfg_valid   = valid_q;
   assign cfg_err     = err_q;
   assign cfg_busy    = (state_q != ST_IDLE);
   assign dbg_state_o = state_q;
   assign dbg_cnt_o   = cnt_q;

endmodule

// File: tb/tb_clb_cfg_chain.sv
// Directed bench for clb_cfg_chain with two 4-bit subtiles (10-bit chain).
module tb_clb_cfg_chain;
   import clb_cfg_pkg::*;

   logic       prog_clk;
   logic       prog_reset;
   logic       ccff_head;
   logic       ccff_en;
   logic       ccff_commit;
   logic       ccff_tail;
   logic [7:0] cfg_out;
   logic       cfg_valid;
   logic       cfg_busy;
   logic       cfg_err;
   cfg_state_e dbg_state;
   logic [3:0] dbg_cnt;

   int total = 0;
   int bad   = 0;

   // Streams are written first-shifted bit on the left.
   localparam logic [9:0]  GOOD_73 = 10'b1011100011;
   localparam logic [9:0]  BADP_73 = 10'b0011100011;
   localparam logic [9:0]  GOOD_A5 = 10'b0101000101;
   localparam logic [14:0] OVER_A5 = 15'b11010_0101000101;

   clb_cfg_chain #(.NUM_SUBTILES(2), .CFG_BITS(4)) dut (
      .prog_clk    (prog_clk),
      .prog_reset  (prog_reset),
      .ccff_head   (ccff_head),
      .ccff_en     (ccff_en),
      .ccff_commit (ccff_commit),
      .ccff_tail   (ccff_tail),
      .cfg_out     (cfg_out),
      .cfg_valid   (cfg_valid),
      .cfg_busy    (cfg_busy),
      .cfg_err     (cfg_err),
      .dbg_state_o (dbg_state),
      .dbg_cnt_o   (dbg_cnt)
   );

   initial prog_clk = 1'b0;
   always #5 prog_clk = ~prog_clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge prog_clk);
      #1;
   endtask

   task automatic shift_bits(input logic [14:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         ccff_en   = 1'b1;
         ccff_head = v[i];
         tick();
      end
      ccff_en = 1'b0;
   endtask

   task automatic do_commit();
      ccff_commit = 1'b1;
      tick();
      ccff_commit = 1'b0;
   endtask

   initial begin
      logic [14:0] ov;
      prog_reset  = 1'b1;
      ccff_head   = 1'b0;
      ccff_en     = 1'b0;
      ccff_commit = 1'b0;
      tick();
      tick();
      check("rst_cfg_out", 16'(cfg_out), 16'h00);
      check("rst_valid", 16'(cfg_valid), 16'h0);
      check("rst_err", 16'(cfg_err), 16'h0);
      check("rst_tail", 16'(ccff_tail), 16'h0);
      check("rst_busy", 16'(cfg_busy), 16'h0);
      check("rst_state", 16'(dbg_state), 16'(ST_IDLE));
      prog_reset = 1'b0;

      // Good load
      shift_bits(15'(GOOD_73), 10);
      check("good_busy_pre", 16'(cfg_busy), 16'h1);
      check("good_state_full", 16'(dbg_state), 16'(ST_FULL));
      check("good_cnt_full", 16'(dbg_cnt), 16'd10);
      check("good_cfg_hold", 16'(cfg_out), 16'h00);
      do_commit();
      check("good_cfg_out", 16'(cfg_out), 16'h73);
      check("good_valid", 16'(cfg_valid), 16'h1);
      check("good_err", 16'(cfg_err), 16'h0);
      check("good_busy_post", 16'(cfg_busy), 16'h0);

      // Underfill
      shift_bits(15'(GOOD_73), 7);
      check("under_state", 16'(dbg_state), 16'(ST_SHIFT));
      check("under_cnt7", 16'(dbg_cnt), 16'd7);
      do_commit();
      check("under_err", 16'(cfg_err), 16'h1);
      check("under_cfg_out", 16'(cfg_out), 16'h73);
      check("under_valid", 16'(cfg_valid), 16'h1);
      check("under_state_idle", 16'(dbg_state), 16'(ST_IDLE));
      check("under_cnt0", 16'(dbg_cnt), 16'd0);

      // Parity failure, then a good load clears the error
      shift_bits(15'(BADP_73), 10);
      do_commit();
      check("par_err", 16'(cfg_err), 16'h1);
      check("par_cfg_out", 16'(cfg_out), 16'h73);
      shift_bits(15'(GOOD_A5), 10);
      do_commit();
      check("par_recover_out", 16'(cfg_out), 16'hA5);
      check("par_recover_err", 16'(cfg_err), 16'h0);

      // Commit together with shift: shift happens, commit ignored, error raised
      shift_bits(15'(GOOD_73 >> 1), 9);
      ccff_en     = 1'b1;
      ccff_head   = GOOD_73[0];
      ccff_commit = 1'b1;
      tick();
      ccff_en     = 1'b0;
      ccff_commit = 1'b0;
      check("both_err", 16'(cfg_err), 16'h1);
      check("both_cfg_out", 16'(cfg_out), 16'hA5);
      check("both_state", 16'(dbg_state), 16'(ST_FULL));
      check("both_cnt", 16'(dbg_cnt), 16'd10);
      do_commit();
      check("both_then_out", 16'(cfg_out), 16'h73);
      check("both_then_err", 16'(cfg_err), 16'h0);

      // Commit in IDLE with an empty chain
      do_commit();
      check("idle_err", 16'(cfg_err), 16'h1);
      check("idle_cfg_out", 16'(cfg_out), 16'h73);
      check("idle_valid", 16'(cfg_valid), 16'h1);

      // Overfill pass-through: tail emits the first five bits at shifts 11..15
      ov = OVER_A5;
      for (int s = 1; s <= 15; s++) begin
         ccff_en   = 1'b1;
         ccff_head = ov[15-s];
         tick();
         if (s >= 11) begin
            check($sformatf("over_tail_s%0d", s), 16'(ccff_tail), 16'(ov[25-s]));
         end
         if (s == 14) begin
            ccff_en = 1'b0;
            tick();
            check("over_tail_hold", 16'(ccff_tail), 16'(ov[11]));
         end
      end
      ccff_en = 1'b0;
      check("over_cnt_sat", 16'(dbg_cnt), 16'd10);
      check("over_state", 16'(dbg_state), 16'(ST_FULL));
      do_commit();
      check("over_cfg_out", 16'(cfg_out), 16'hA5);
      check("over_err", 16'(cfg_err), 16'h0);

      // Reset in the middle of a shift sequence
      shift_bits(15'h1f, 5);
      check("mid_cnt5", 16'(dbg_cnt), 16'd5);
      prog_reset  = 1'b1;
      ccff_en     = 1'b1;
      ccff_head   = 1'b1;
      ccff_commit = 1'b1;
      tick();
      prog_reset  = 1'b0;
      ccff_en     = 1'b0;
      ccff_commit = 1'b0;
      check("mid_rst_out", 16'(cfg_out), 16'h00);
      check("mid_rst_valid", 16'(cfg_valid), 16'h0);
      check("mid_rst_err", 16'(cfg_err), 16'h0);
      check("mid_rst_tail", 16'(ccff_tail), 16'h0);
      check("mid_rst_state", 16'(dbg_state), 16'(ST_IDLE));
      check("mid_rst_cnt", 16'(dbg_cnt), 16'd0);
      shift_bits(15'(GOOD_73), 10);
      check("mid_sr_cleared", 16'(ccff_tail), 16'h0);
      do_commit();
      check("mid_cfg_out", 16'(cfg_out), 16'h73);
      check("mid_valid", 16'(cfg_valid), 16'h1);
      check("mid_err", 16'(cfg_err), 16'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
